// File: rtl/pconv_unit_cn_pkg.sv
// Shared types and helpers for the pointwise-convolution unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: default geometry, product width and adder-tree depth, the FSM state
// type, and clamp_n(), which saturates a wide signed value to an n-bit signed range.
package pconv_pkg;

  localparam int PCONV_N_DEF  = 16;
  localparam int PCONV_CH_DEF = 6;

  // Product of two N-bit signed operands needs 2N bits.
  localparam int PROD_W     = 2 * PCONV_N_DEF;
  // Number of pairwise-add levels needed to reduce CH lanes to one.
  localparam int TREE_DEPTH = (PCONV_CH_DEF > 1) ? $clog2(PCONV_CH_DEF) : 0;

  // Working width of clamp_n(); the accumulator must not be wider than this.
  localparam int CLAMP_W = 64;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    OUT   = 2'd3
  } pconv_state_e;

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  function automatic int tree_depth(input int ch);
    return (ch > 1) ? $clog2(ch) : 0;
  endfunction

  // Signed saturation to [-2^(n-1), 2^(n-1)-1].
  function automatic logic signed [CLAMP_W-1:0] clamp_n(input logic signed [CLAMP_W-1:0] value,
                                                        input int n);
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/pconv_unit_cn_add_tree.sv
// Registered CH-input signed adder tree: sign-extends each lane and sums them.
// Latency: 1 cycle (single output register after a combinational binary tree).
// Backpressure: en low freezes the output register; there is no handshake.
// Ports: clk, rst (async active-high), en, din (CH lanes of IN_W bits),
// sum (OUT_W-bit signed total).
module pconv_add_tree
  import pconv_pkg::*;
#(
  parameter int CH    = PCONV_CH_DEF,
  parameter int IN_W  = PROD_W,
  parameter int OUT_W = 32,
  parameter int DEPTH = TREE_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CH*IN_W-1:0]      din,
  output logic signed [OUT_W-1:0] sum
);

  localparam int LEAVES = 1 << DEPTH;

  // Heap layout: node[1] is the root, children of node[k] are node[2k] and
  // node[2k+1], leaves start at node[LEAVES]. Unused leaves stay zero.
  logic signed [OUT_W-1:0] node [1:2*LEAVES-1];

  always_comb begin
    for (int k = 1; k < 2 * LEAVES; k++) node[k] = '0;
    for (int i = 0; i < CH; i++) node[LEAVES + i] = OUT_W'($signed(din[i*IN_W +: IN_W]));
    for (int k = LEAVES - 1; k >= 1; k--) node[k] = node[2*k] + node[2*k + 1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     sum <= '0;
    else if (en) sum <= node[1];
  end

endmodule

// File: rtl/pconv_unit_cn.sv
// Pointwise convolution: CH products per beat, tree sum, GROUPS-beat accumulate, bias, shift, clamp.
// Latency: 4 cycles from last beat of a group to dout_vld (plus any ce-low cycles).
// Backpressure: in_rdy low outside ACCUM or when ce low; result parks in HOLD until dout is free.
// Ports: clk, rst (async active-high), ce, in_vld/in_rdy, input_din/weight_din (CH x N signed),
// bias_din (ACC_W), shift_din (5), dout (N) with dout_vld/dout_rdy.
// Build option: define PCONV_CN_RELU_EN for ReLU clamping (negatives to 0); otherwise signed saturation.
module pconv_unit_cn
  import pconv_pkg::*;
#(
  parameter int N      = PCONV_N_DEF,
  parameter int CH     = PCONV_CH_DEF,
  parameter int GROUPS = 1,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [CH*N-1:0]   input_din,
  input  logic [CH*N-1:0]   weight_din,
  input  logic [ACC_W-1:0]  bias_din,
  input  logic [4:0]        shift_din,
  output logic [N-1:0]      dout,
  output logic              dout_vld,
  input  logic              dout_rdy
);

  localparam int PW    = prod_w(N);
  localparam int CNT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

  pconv_state_e            state;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic                    last_beat;
  logic                    out_free;
  logic                    load;
  logic [CH*PW-1:0]        prod_q;
  logic                    p_vld, p_last;
  logic                    s_vld, s_last;
  logic                    a_done;
  logic signed [ACC_W-1:0] s_sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_q;
  logic [4:0]              shift_q;
  logic signed [ACC_W-1:0] y;
  logic [N-1:0]            y_clamp;

  assign in_rdy    = ce && (state == ACCUM) && !rst;
  assign accept    = in_vld && in_rdy;
  assign last_beat = (cnt == LAST_CNT);
  assign out_free  = !dout_vld || dout_rdy;
  // Transfer of the finished sum into the output register. a_done is only set
  // once the last beat has left stage A, and stays set while parked in HOLD.
  assign load      = ce && out_free && a_done && ((state == DRAIN) || (state == HOLD));

  // Group counter; bias and shift are taken with the last beat of each group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bias_q  <= '0;
      shift_q <= '0;
    end else if (accept) begin
      if (last_beat) begin
        cnt     <= '0;
        bias_q  <= $signed(bias_din);
        shift_q <= shift_din;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Stage P: one signed NxN product per lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      p_vld  <= 1'b0;
      p_last <= 1'b0;
    end else if (ce) begin
      p_vld  <= accept;
      p_last <= accept && last_beat;
      if (accept) begin
        for (int i = 0; i < CH; i++) begin
          prod_q[i*PW +: PW] <= PW'($signed(input_din[i*N +: N])) * PW'($signed(weight_din[i*N +: N]));
        end
      end
    end
  end

  // Stage S: registered adder tree, flags follow alongside.
  pconv_add_tree #(
    .CH    (CH),
    .IN_W  (PW),
    .OUT_W (ACC_W),
    .DEPTH (tree_depth(CH))
  ) u_tree (
    .clk (clk),
    .rst (rst),
    .en  (ce),
    .din (prod_q),
    .sum (s_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld  <= 1'b0;
      s_last <= 1'b0;
    end else if (ce) begin
      s_vld  <= p_vld;
      s_last <= p_last;
    end
  end

  // Stage A: wrapping accumulate; the last beat also folds in the bias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      a_done <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      a_done <= 1'b0;
    end else if (ce && s_vld) begin
      acc    <= acc + s_sum + (s_last ? bias_q : '0);
      a_done <= s_last;
    end
  end

  assign y = acc >>> shift_q;

  always_comb begin
`ifdef PCONV_CN_RELU_EN
    y_clamp = (y < 0) ? '0 : N'(clamp_n(CLAMP_W'(y), N));
`else
    y_clamp = N'(clamp_n(CLAMP_W'(y), N));
`endif
  end

  // Control FSM with the registered output stage. The output handshake runs
  // regardless of ce; a load in the same cycle as a take keeps dout_vld high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      if (load) begin
        dout     <= y_clamp;
        dout_vld <= 1'b1;
      end else if (dout_rdy) begin
        dout_vld <= 1'b0;
      end
      if (ce) begin
        case (state)
          ACCUM:   if (accept && last_beat) state <= DRAIN;
          DRAIN:   if (a_done) state <= out_free ? OUT : HOLD;
          HOLD:    if (out_free) state <= ACCUM;
          OUT:     state <= ACCUM;
          default: state <= ACCUM;
        endcase
      end
    end
  end

endmodule
